// File: rtl/lms_err_step.sv
// Per-sample controller and error stage for the adaptive LMS tap chain.
// It drives one chain update per sample, then forms y, e = d - y and the next step mu*e.
module lms_err_step #(
    parameter int SETTLE_CYC = 2,
    parameter int Y_SHIFT    = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] d_in,
    input  logic signed [15:0] mu,
    output logic signed [15:0] tap_data,
    output logic               tap_enable,
    output logic signed [15:0] tap_step,
    output logic signed [31:0] tap_sum_in,
    input  logic signed [31:0] sum_fb,
    output logic               m_valid,
    input  logic               m_ready,
    output logic signed [15:0] y_out,
    output logic signed [15:0] e_out,
    input  logic               sat_clr,
    output logic               sat_flag
);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAP, SCALE, OUT} state_t;

    localparam logic signed [32:0] Y_ROUND = 33'sd1 <<< (Y_SHIFT - 1);
    localparam logic [3:0]         WAIT_LAST = 4'(SETTLE_CYC - 1);

    state_t             state, state_nxt;
    logic [3:0]         wait_cnt;
    logic signed [15:0] d_r;

    logic signed [32:0] y_wide;
    logic signed [15:0] y_sat;
    logic signed [16:0] e_diff;
    logic signed [32:0] e_wide;
    logic signed [31:0] prod;
    logic signed [32:0] step_wide;
    logic               cap_ovf;
    logic               scale_ovf;

    function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767)
            return 16'sh7fff;
        else if (v < -33'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    function automatic logic ovf16(input logic signed [32:0] v);
        return (v > 33'sd32767) || (v < -33'sd32768);
    endfunction

    assign tap_sum_in = '0;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_valid) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = CAP;
            CAP:     state_nxt = SCALE;
            SCALE:   state_nxt = OUT;
            OUT:     if (m_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; defaults first so no path leaves an output unassigned.
    always_comb begin
        s_ready    = 1'b0;
        tap_enable = 1'b0;
        m_valid    = 1'b0;
        case (state)
            IDLE:    s_ready    = 1'b1;
            LOAD:    tap_enable = 1'b1;
            OUT:     m_valid    = 1'b1;
            default: ;
        endcase
    end

    // Rounded output, error and step; y rounds half-up before the arithmetic shift.
    always_comb begin
        y_wide    = (33'(sum_fb) + Y_ROUND) >>> Y_SHIFT;
        y_sat     = sat16(y_wide);
        e_diff    = 17'(d_r) - 17'(y_sat);
        e_wide    = 33'(e_diff);
        prod      = 32'(mu) * 32'(e_out);
        step_wide = (33'(prod) + 33'sd16384) >>> 15;
        cap_ovf   = ovf16(y_wide) || ovf16(e_wide);
        scale_ovf = ovf16(step_wide);
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            tap_data <= '0;
            d_r      <= '0;
            y_out    <= '0;
            e_out    <= '0;
            tap_step <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        tap_data <= x_in;
                        d_r      <= d_in;
                    end
                end
                LOAD:  wait_cnt <= '0;
                WAIT:  wait_cnt <= wait_cnt + 4'd1;
                CAP: begin
                    y_out <= y_sat;
                    e_out <= sat16(e_wide);
                end
                SCALE: tap_step <= sat16(step_wide);
                default: ;
            endcase
        end
    end

    // Sticky saturation flag; a new clamp overrides a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_flag <= 1'b0;
        else if ((state == CAP && cap_ovf) || (state == SCALE && scale_ovf))
            sat_flag <= 1'b1;
        else if (sat_clr)
            sat_flag <= 1'b0;
    end

endmodule

// File: doc/lms_err_step.md
# lms_err_step

Per-sample controller and error stage for the adaptive LMS tap chain. It accepts one reference/desired sample pair per handshake and feeds the chain's `data_in`, `enable`, `Step_size` and `Sum_in`. It then waits for the chain's `Sum_out` to settle, forms the filter output y and the error e = d − y, and computes the next step term mu·e. The resulting step is applied on the next sample's update. y and e are presented downstream on a valid/ready handshake.

## Interface
- `SETTLE_CYC`, default 2: cycles waited after the `tap_enable` pulse before `sum_fb` is sampled; legal range 1..15.
- `Y_SHIFT`, default 15: fractional bits of `sum_fb`; legal range 1..16.
- `clk`  in  1  single clock domain, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  input sample pair valid.
- `s_ready`  out  1  block can accept a pair.
- `x_in`  in  16 signed  reference sample.
- `d_in`  in  16 signed  desired sample.
- `mu`  in  16 signed  step size, Q1.15; sampled in SCALE.
- `tap_data`  out  16 signed  to chain `data_in`; registered x.
- `tap_enable`  out  1  to chain `enable`; one-cycle pulse.
- `tap_step`  out  16 signed  to chain `Step_size`; registered.
- `tap_sum_in`  out  32 signed  to chain `Sum_in`; constant 0.
- `sum_fb`  in  32 signed  from chain `Sum_out`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream accepts the result.
- `y_out`  out  16 signed  filter output.
- `e_out`  out  16 signed  error.
- `sat_clr`  in  1  synchronous clear of `sat_flag`.
- `sat_flag`  out  1  sticky flag; set on any saturation.

## Operation
- FSM states: IDLE, LOAD, WAIT, CAP, SCALE, OUT.
- IDLE: `s_ready`=1. When `s_valid`&`s_ready`, latch `x_in` into `tap_data` and `d_in` into `d_r`, then go to LOAD.
- LOAD: `tap_enable`=1 for exactly one cycle. The chain shifts x and updates its weights using the current `tap_step`, which is mu·e of the previous sample. Next state is WAIT with the wait counter cleared.
- WAIT: the counter increments each cycle. After `SETTLE_CYC` cycles in WAIT, go to CAP.
- CAP: compute y and e as defined below. Register `y_out`, `e_out` and go to SCALE.
- SCALE: compute the step as defined below. Register `tap_step` and go to OUT.
- OUT: `m_valid`=1, with `y_out` and `e_out` held stable. When `m_ready`=1, return to IDLE.
- y = saturate16((sum_fb + 2^(Y_SHIFT−1)) >>> Y_SHIFT). Evaluated in 33 bits: round half-up, then arithmetic shift.
- e = saturate16(d_r − y). Evaluated in 17 bits.
- step = saturate16((mu·e + 2^14) >>> 15). The product is 32 bits; the sum is 33 bits.
- Saturation clamps to [−32768, 32767].
- Any clamp sets `sat_flag`. `sat_clr` clears it. If both happen in the same cycle, set wins.
- `tap_data` and `tap_step` hold their values outside LOAD and SCALE respectively.
- `s_valid` is ignored in every state except IDLE.

## Timing
- Let T be the handshake cycle.
- `tap_enable` is high during T+1.
- `sum_fb` is sampled during T+2+SETTLE_CYC.
- `tap_step` updates at the end of T+3+SETTLE_CYC.
- `m_valid` rises at T+4+SETTLE_CYC, i.e. T+6 with the default `SETTLE_CYC`.
- `s_ready` rises the cycle after the `m_valid`&`m_ready` cycle.
- Throughput with no backpressure is one sample per SETTLE_CYC+5 cycles.
- `reset`: all outputs and registers are 0, except `s_ready`, which is 1 (state is IDLE). In particular `tap_step`=0, so the first update after reset has zero adaptation.
- Reset asserted in any state aborts the current sample immediately. No `m_valid` is issued and no further `tap_enable` pulse occurs.
- `mu` change: takes effect only for a SCALE that begins after the change.
- `m_ready` high with `m_valid` low has no effect.

## Test plan
- Reset: assert `reset` mid-cycle, release. Required: all outputs 0, `s_ready`=1, `tap_sum_in`=0.
- Basic sample:
  - Stimulus: `x_in`=1000, `d_in`=300, `mu`=16384; `sum_fb` held at 3276800; `m_ready`=1.
  - `tap_data`=1000 and `tap_enable`=1 at T+1.
  - At T+6: `m_valid`=1, `y_out`=100, `e_out`=200.
  - `tap_step`=100.
- Saturation:
  - Stimulus: `sum_fb`=0x7FFFFFFF, `d_in`=−32768, `mu`=32767.
  - Required: `y_out`=32767, `e_out`=−32768, `tap_step`=−32767, `sat_flag`=1.
  - Pulse `sat_clr` afterwards. Required: `sat_flag`=0.
- Backpressure:
  - Stimulus: `m_ready`=0 for 10 cycles, with `s_valid` pulsed during the stall.
  - Required: `m_valid`, `y_out`, `e_out` stable; `s_ready`=0; no `tap_enable` pulse; the stalled sample is not accepted.
- Back-to-back:
  - Stimulus: two samples, with the basic-sample values as the first.
  - Required: `tap_step`=0 during the first LOAD and 100 during the second LOAD.
- Reset mid-operation:
  - Stimulus: assert `reset` at T+3 (WAIT).
  - Required: state IDLE, `tap_step`=0, no `m_valid`.
  - The next accepted sample completes normally at +6.
